// File: rtl/stream_mux_rr_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr_if
// Description : Bundles the N-channel input streams, the mode/select controls
//               and the single output stream of stream_mux_rr.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_mux_rr_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4
);
  localparam int SEL_W = $clog2(N_CH);

  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [N_CH*WIDTH-1:0]   in_data;
  logic [N_CH-1:0]         in_valid;
  logic [N_CH-1:0]         in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_ch;

  // Source/consumer side: drives the input streams and the consumer ready
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  // Multiplexer side
  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : N-channel registered stream multiplexer with valid/ready
//               handshake. Mode 0 forwards the channel picked by sel, mode 1
//               arbitrates round-robin among valid channels.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4
) (
  input  wire             clk,
  input  wire             rst_n,
  stream_mux_rr_if.slave  bus
);
  localparam int SEL_W = $clog2(N_CH);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_ch;
  logic [SEL_W-1:0] r_rr_last;

  logic [WIDTH-1:0] w_ch_data [N_CH];
  logic             w_load_en;
  logic             w_sel_vld;
  logic             w_rr_vld;
  logic [SEL_W-1:0] w_rr_gnt;
  logic             w_gnt_vld;
  logic [SEL_W-1:0] w_gnt;
  logic [WIDTH-1:0] w_gnt_data;
  logic [N_CH-1:0]  w_in_ready;

  // Split the flat input bus into one word per channel
  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign w_ch_data[k] = bus.in_data[k*WIDTH +: WIDTH];
  end

  // The output register may take a new word when empty or being drained
  assign w_load_en = !r_out_valid || bus.out_ready;

  // Direct select: an out-of-range sel never matches any channel index
  always_comb begin
    w_sel_vld = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if ((SEL_W'(k) == bus.sel) && bus.in_valid[k]) w_sel_vld = 1'b1;
    end
  end

  // Round-robin: pick the valid channel closest above rr_last (mod N_CH),
  // so rr_last itself sits at distance N_CH-1 and has lowest priority
  always_comb begin
    int best_d;
    int d;
    w_rr_vld = 1'b0;
    w_rr_gnt = '0;
    best_d   = N_CH;
    for (int k = 0; k < N_CH; k++) begin
      d = k - int'(r_rr_last) - 1;
      if (d < 0) d = d + N_CH;
      if (bus.in_valid[k] && (d < best_d)) begin
        best_d   = d;
        w_rr_vld = 1'b1;
        w_rr_gnt = SEL_W'(k);
      end
    end
  end

  // Final grant for the active mode
  always_comb begin
    w_gnt_vld = bus.mode ? w_rr_vld : w_sel_vld;
    w_gnt     = bus.mode ? w_rr_gnt : bus.sel;
  end

  // Data of the granted channel
  always_comb begin
    w_gnt_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (SEL_W'(k) == w_gnt) w_gnt_data = w_ch_data[k];
    end
  end

  // One-hot ready towards the granted channel; all low while in reset
  always_comb begin
    w_in_ready = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_in_ready[k] = rst_n && w_load_en && w_gnt_vld && (w_gnt == SEL_W'(k));
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_rr_last   <= SEL_W'(N_CH - 1);
    end else if (w_load_en) begin
      if (w_gnt_vld) begin
        r_out_data  <= w_gnt_data;
        r_out_ch    <= w_gnt;
        r_out_valid <= 1'b1;
        r_rr_last   <= w_gnt;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_ch    = r_out_ch;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux_rr
// Description : Directed self-checking bench for stream_mux_rr (8-bit, 4 ch).
//               Expected output words are queued when stimulus is applied and
//               popped when the corresponding word appears at the output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;
  localparam int WIDTH = 8;
  localparam int N_CH  = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [9:0] sb [$];  // {data[7:0], ch[1:0]}
  logic [7:0] ch_val [4];

  stream_mux_rr_if #(.WIDTH(WIDTH), .N_CH(N_CH)) bus ();

  stream_mux_rr #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] c);
    sb.push_back({d, c});
  endtask

  task automatic check_word(input string tag);
    logic [9:0] e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_data"},  32'(bus.out_data),  32'(e[9:2]));
      chk({tag, "_ch"},    32'(bus.out_ch),    32'(e[1:0]));
    end
  endtask

  task automatic set_data();
    bus.in_data = {ch_val[3], ch_val[2], ch_val[1], ch_val[0]};
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ch_val[0] = 8'h0f; ch_val[1] = 8'hf0; ch_val[2] = 8'hfa; ch_val[3] = 8'hbf;

    // 1: reset with every channel requesting
    rst_n         = 1'b0;
    bus.mode      = 1'b1;
    bus.sel       = 2'd0;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    set_data();
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_ch",    32'(bus.out_ch),    32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    rst_n = 1'b1;
    #1;
    chk("first_gnt_ready", 32'(bus.in_ready), 32'b0001);
    push(8'h0f, 2'd0);
    tick();
    check_word("first_gnt");

    // 2: direct select of channel 1
    bus.mode     = 1'b0;
    bus.sel      = 2'd1;
    bus.in_valid = 4'b0010;
    #1;
    chk("m0_sel1_ready", 32'(bus.in_ready), 32'b0010);
    push(8'hf0, 2'd1);
    tick();
    check_word("m0_sel1");

    // 3: selected channel idle -> no grant, output drains, data held
    bus.sel      = 2'd2;
    bus.in_valid = 4'b1011;
    #1;
    chk("m0_idle_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("m0_idle_valid", 32'(bus.out_valid), 32'd0);
    chk("m0_idle_data",  32'(bus.out_data),  32'hf0);
    chk("m0_idle_ch",    32'(bus.out_ch),    32'd1);
    ch_val[3] = 8'hfa;
    set_data();
    bus.sel = 2'd3;
    #1;
    chk("m0_sel3_ready", 32'(bus.in_ready), 32'b1000);
    push(8'hfa, 2'd3);
    tick();
    check_word("m0_sel3");

    // 4: round-robin with all channels valid, starting after ch3
    ch_val[3] = 8'hbf;
    set_data();
    bus.mode     = 1'b1;
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_ready", 32'(bus.in_ready), 32'(1 << (i % 4)));
      push(ch_val[i % 4], 2'(i % 4));
      tick();
      check_word("rr_seq");
    end

    // 5: backpressure holds ch0 word; then ch1 follows
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(bus.in_ready), 32'd0);
      tick();
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_data",  32'(bus.out_data),  32'h0f);
      chk("bp_ch",    32'(bus.out_ch),    32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'b0010);
    push(8'hf0, 2'd1);
    tick();
    check_word("bp_release");

    // 6: grant ch2, then async reset pulse between edges
    push(8'hfa, 2'd2);
    tick();
    check_word("pre_reset");
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_ready", 32'(bus.in_ready),  32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'b0001);
    push(8'h0f, 2'd0);
    tick();
    check_word("post_rst");

    // single requester is granted every cycle
    bus.in_valid = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("single_ready", 32'(bus.in_ready), 32'b0100);
      push(8'hfa, 2'd2);
      tick();
      check_word("single");
    end

    // flush: nothing left pending, output drains
    bus.in_valid = 4'b0000;
    tick();
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("sb_empty",    32'(sb.size()),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
